// File: rtl/commit_recovery_ctrl.sv
// rtl/commit_recovery_ctrl.sv - ROB-head retirement sequencer with RAT-copy recovery
module commit_recovery_ctrl #(
    parameter int ARCH_LOG2  = 5,
    parameter int PREG_WIDTH = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FREEZE,
    input  logic                  head_valid_IN,
    input  logic                  head_fin_IN,
    input  logic                  head_exc_IN,
    input  logic                  head_wr_IN,
    input  logic [ARCH_LOG2-1:0]  head_arch_IN,
    input  logic [PREG_WIDTH-1:0] head_preg_IN,
    input  logic                  fl_full_IN,
    output logic                  rob_pop_OUT,
    output logic                  fl_push_OUT,
    output logic [PREG_WIDTH-1:0] fl_data_OUT,
    output logic                  flush_OUT,
    output logic                  copy_we_OUT,
    output logic [ARCH_LOG2-1:0]  copy_idx_OUT,
    output logic [PREG_WIDTH-1:0] copy_data_OUT,
    output logic                  busy_OUT,
    output logic                  recov_done_OUT,
    output logic [CNT_WIDTH-1:0]  retired_cnt_OUT
);

    localparam int N = 1 << ARCH_LOG2;
    localparam logic [ARCH_LOG2-1:0] IDX_LAST = {ARCH_LOG2{1'b1}};
    localparam logic [ARCH_LOG2-1:0] IDX_ONE  = ARCH_LOG2'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_COPY  = 2'd2
    } state_t;

    state_t                r_state;
    logic [PREG_WIDTH-1:0] r_ret_rat [N];
    logic [ARCH_LOG2-1:0]  r_idx;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_flush;
    logic                  r_busy;
    logic                  r_copy_we;
    logic                  r_done;

    logic w_idle;
    logic w_ready;
    logic w_frees;
    logic w_commit;
    logic w_exc;

    // Arch reg 0 is hardwired: writing it neither remaps nor frees a tag.
    assign w_idle   = RESET && !FREEZE && (r_state == ST_IDLE);
    assign w_ready  = head_valid_IN && head_fin_IN;
    assign w_frees  = head_wr_IN && (head_arch_IN != '0);
    assign w_commit = w_idle && w_ready && !head_exc_IN && !(w_frees && fl_full_IN);
    assign w_exc    = w_idle && w_ready && head_exc_IN;

    assign rob_pop_OUT     = w_commit;
    assign fl_push_OUT     = w_commit && w_frees;
    assign fl_data_OUT     = r_ret_rat[head_arch_IN];
    assign flush_OUT       = r_flush;
    assign copy_we_OUT     = r_copy_we && !FREEZE;
    assign copy_idx_OUT    = r_idx;
    assign copy_data_OUT   = r_ret_rat[r_idx];
    assign busy_OUT        = r_busy;
    assign recov_done_OUT  = r_done;
    assign retired_cnt_OUT = r_cnt;

    // Retirement/recovery FSM: retires in IDLE, flushes one cycle, then walks the retRAT.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_flush   <= 1'b0;
            r_busy    <= 1'b0;
            r_copy_we <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_ret_rat[i] <= PREG_WIDTH'(i);
            end
        end else if (!FREEZE) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_commit) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_frees) begin
                            r_ret_rat[head_arch_IN] <= head_preg_IN;
                        end
                    end else if (w_exc) begin
                        r_state <= ST_FLUSH;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_state   <= ST_COPY;
                    r_idx     <= '0;
                    r_flush   <= 1'b0;
                    r_copy_we <= 1'b1;
                    r_done    <= (IDX_LAST == '0);
                end
                ST_COPY: begin
                    if (r_idx == IDX_LAST) begin
                        r_state   <= ST_IDLE;
                        r_idx     <= '0;
                        r_busy    <= 1'b0;
                        r_copy_we <= 1'b0;
                        r_done    <= 1'b0;
                    end else begin
                        r_idx  <= r_idx + IDX_ONE;
                        r_done <= ((r_idx + IDX_ONE) == IDX_LAST);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_flush   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_copy_we <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_recovery_ctrl.sv
// tb/tb_commit_recovery_ctrl.sv - directed self-checking bench for commit_recovery_ctrl
module tb_commit_recovery_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FREEZE;
    logic        head_valid_IN;
    logic        head_fin_IN;
    logic        head_exc_IN;
    logic        head_wr_IN;
    logic [4:0]  head_arch_IN;
    logic [5:0]  head_preg_IN;
    logic        fl_full_IN;
    logic        rob_pop_OUT;
    logic        fl_push_OUT;
    logic [5:0]  fl_data_OUT;
    logic        flush_OUT;
    logic        copy_we_OUT;
    logic [4:0]  copy_idx_OUT;
    logic [5:0]  copy_data_OUT;
    logic        busy_OUT;
    logic        recov_done_OUT;
    logic [31:0] retired_cnt_OUT;

    int total = 0;
    int bad   = 0;

    commit_recovery_ctrl #(
        .ARCH_LOG2  (5),
        .PREG_WIDTH (6),
        .CNT_WIDTH  (32)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .FREEZE          (FREEZE),
        .head_valid_IN   (head_valid_IN),
        .head_fin_IN     (head_fin_IN),
        .head_exc_IN     (head_exc_IN),
        .head_wr_IN      (head_wr_IN),
        .head_arch_IN    (head_arch_IN),
        .head_preg_IN    (head_preg_IN),
        .fl_full_IN      (fl_full_IN),
        .rob_pop_OUT     (rob_pop_OUT),
        .fl_push_OUT     (fl_push_OUT),
        .fl_data_OUT     (fl_data_OUT),
        .flush_OUT       (flush_OUT),
        .copy_we_OUT     (copy_we_OUT),
        .copy_idx_OUT    (copy_idx_OUT),
        .copy_data_OUT   (copy_data_OUT),
        .busy_OUT        (busy_OUT),
        .recov_done_OUT  (recov_done_OUT),
        .retired_cnt_OUT (retired_cnt_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_head(input logic v, input logic f, input logic e, input logic w,
                            input logic [4:0] a, input logic [5:0] p);
        head_valid_IN = v;
        head_fin_IN   = f;
        head_exc_IN   = e;
        head_wr_IN    = w;
        head_arch_IN  = a;
        head_preg_IN  = p;
    endtask

    initial begin
        RESET      = 1'b0;
        FREEZE     = 1'b0;
        fl_full_IN = 1'b0;
        set_head(0, 0, 0, 0, 5'd0, 6'd0);
        tick();
        tick();

        // Reset state
        chk("rst_pop",   32'(rob_pop_OUT), 32'd0);
        chk("rst_push",  32'(fl_push_OUT), 32'd0);
        chk("rst_flush", 32'(flush_OUT), 32'd0);
        chk("rst_we",    32'(copy_we_OUT), 32'd0);
        chk("rst_idx",   32'(copy_idx_OUT), 32'd0);
        chk("rst_cdata", 32'(copy_data_OUT), 32'd0);
        chk("rst_busy",  32'(busy_OUT), 32'd0);
        chk("rst_done",  32'(recov_done_OUT), 32'd0);
        chk("rst_cnt",   retired_cnt_OUT, 32'd0);
        RESET = 1'b1;
        tick();

        // Identity retRAT, read through the free-list data port with no valid head
        for (int i = 0; i < 32; i++) begin
            head_arch_IN = 5'(i);
            #1;
            chk("ident", 32'(fl_data_OUT), 32'(i));
        end
        tick();

        // Commit arch 3 -> preg 40
        set_head(1, 1, 0, 1, 5'd3, 6'd40);
        #1;
        chk("c1_pop",  32'(rob_pop_OUT), 32'd1);
        chk("c1_push", 32'(fl_push_OUT), 32'd1);
        chk("c1_data", 32'(fl_data_OUT), 32'd3);
        tick();
        set_head(0, 0, 0, 0, 5'd3, 6'd0);
        #1;
        chk("c1_rat3", 32'(fl_data_OUT), 32'd40);
        chk("c1_cnt",  retired_cnt_OUT, 32'd1);

        // Same head blocked by full free list for 4 cycles
        set_head(1, 1, 0, 1, 5'd3, 6'd40);
        fl_full_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_pop",  32'(rob_pop_OUT), 32'd0);
            chk("full_push", 32'(fl_push_OUT), 32'd0);
            chk("full_cnt",  retired_cnt_OUT, 32'd1);
            tick();
        end
        fl_full_IN = 1'b0;
        #1;
        chk("unfull_pop",  32'(rob_pop_OUT), 32'd1);
        chk("unfull_push", 32'(fl_push_OUT), 32'd1);
        chk("unfull_data", 32'(fl_data_OUT), 32'd40);
        tick();
        chk("unfull_cnt", retired_cnt_OUT, 32'd2);

        // FREEZE holds a committable head
        FREEZE = 1'b1;
        set_head(1, 1, 0, 0, 5'd9, 6'd9);
        #1;
        chk("frz_pop", 32'(rob_pop_OUT), 32'd0);
        tick();
        chk("frz_cnt", retired_cnt_OUT, 32'd2);
        FREEZE = 1'b0;

        // Arch 0 write: pops and counts, never frees or remaps
        set_head(1, 1, 0, 1, 5'd0, 6'd50);
        fl_full_IN = 1'b1;
        #1;
        chk("a0_pop",  32'(rob_pop_OUT), 32'd1);
        chk("a0_push", 32'(fl_push_OUT), 32'd0);
        tick();
        fl_full_IN = 1'b0;
        set_head(0, 0, 0, 0, 5'd0, 6'd0);
        #1;
        chk("a0_rat0", 32'(fl_data_OUT), 32'd0);
        chk("a0_cnt",  retired_cnt_OUT, 32'd3);

        // No destination write
        set_head(1, 1, 0, 0, 5'd7, 6'd9);
        #1;
        chk("nw_pop",  32'(rob_pop_OUT), 32'd1);
        chk("nw_push", 32'(fl_push_OUT), 32'd0);
        tick();
        set_head(0, 0, 0, 0, 5'd7, 6'd0);
        #1;
        chk("nw_cnt",  retired_cnt_OUT, 32'd4);
        chk("nw_rat7", 32'(fl_data_OUT), 32'd7);

        // Unfinished head stalls
        set_head(1, 0, 0, 1, 5'd4, 6'd20);
        #1;
        chk("unfin_pop", 32'(rob_pop_OUT), 32'd0);
        tick();

        // Exception head, with fl_full asserted; head held throughout recovery
        set_head(1, 1, 1, 1, 5'd5, 6'd33);
        fl_full_IN = 1'b1;
        #1;
        chk("exc_pop", 32'(rob_pop_OUT), 32'd0);
        tick();
        chk("fl_flush", 32'(flush_OUT), 32'd1);
        chk("fl_busy",  32'(busy_OUT), 32'd1);
        chk("fl_we",    32'(copy_we_OUT), 32'd0);
        chk("fl_pop",   32'(rob_pop_OUT), 32'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                FREEZE = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    #1;
                    chk("frz_we",   32'(copy_we_OUT), 32'd0);
                    chk("frz_idx",  32'(copy_idx_OUT), 32'd10);
                    chk("frz_busy", 32'(busy_OUT), 32'd1);
                    tick();
                end
                FREEZE = 1'b0;
                #1;
            end
            chk("cp_we",    32'(copy_we_OUT), 32'd1);
            chk("cp_idx",   32'(copy_idx_OUT), 32'(i));
            chk("cp_data",  32'(copy_data_OUT), (i == 3) ? 32'd40 : 32'(i));
            chk("cp_done",  32'(recov_done_OUT), (i == 31) ? 32'd1 : 32'd0);
            chk("cp_flush", 32'(flush_OUT), 32'd0);
            chk("cp_busy",  32'(busy_OUT), 32'd1);
            chk("cp_pop",   32'(rob_pop_OUT), 32'd0);
            if (i == 31) begin
                set_head(0, 0, 0, 0, 5'd3, 6'd0);
                fl_full_IN = 1'b0;
            end
            tick();
        end
        chk("end_busy", 32'(busy_OUT), 32'd0);
        chk("end_we",   32'(copy_we_OUT), 32'd0);
        chk("end_done", 32'(recov_done_OUT), 32'd0);
        chk("end_cnt",  retired_cnt_OUT, 32'd4);
        chk("end_rat3", 32'(fl_data_OUT), 32'd40);

        // Reset mid-COPY
        set_head(1, 1, 1, 0, 5'd1, 6'd1);
        tick();
        set_head(0, 0, 0, 0, 5'd3, 6'd0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("mr_idx", 32'(copy_idx_OUT), 32'd5);
        RESET = 1'b0;
        tick();
        chk("mr_busy", 32'(busy_OUT), 32'd0);
        chk("mr_we",   32'(copy_we_OUT), 32'd0);
        chk("mr_idx0", 32'(copy_idx_OUT), 32'd0);
        chk("mr_rat3", 32'(fl_data_OUT), 32'd3);
        chk("mr_cnt",  retired_cnt_OUT, 32'd0);
        RESET = 1'b1;
        tick();

        // Back in IDLE: a fresh commit works
        set_head(1, 1, 0, 1, 5'd3, 6'd12);
        #1;
        chk("post_pop",  32'(rob_pop_OUT), 32'd1);
        chk("post_data", 32'(fl_data_OUT), 32'd3);
        tick();
        chk("post_cnt",  retired_cnt_OUT, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
